mod_addsub_pipe: RTL and testbench

//   Pipelined, multi-lane modular adder/subtractor for the PQ vector datapath.

---
 rtl/mod_addsub_pipe.sv | 143 ++++++++++++++
 tb/tb_mod_addsub_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_pipe.sv
// Pipelined multi-lane modular adder/subtractor: (a +/- b) mod q on LANES lanes per beat,
// valid/ready on both sides, depth STAGES (1 or 2).
`timescale 1ns/1ps
module mod_addsub_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LANES      = 8,
   parameter int unsigned STAGES     = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic                        mode_i,
   input  logic [DATA_WIDTH-1:0]       q_i,
   input  logic [LANES*DATA_WIDTH-1:0] op0_i,
   input  logic [LANES*DATA_WIDTH-1:0] op1_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [LANES*DATA_WIDTH-1:0] res_o,
   output logic                        busy_o
);

   localparam int unsigned DW  = DATA_WIDTH;
   localparam int unsigned RW  = DW + 1;
   localparam int unsigned BW  = LANES * DW;
   localparam int unsigned RBW = LANES * RW;

   // Raw sum (carry kept) or two's-complement difference with sign in the top bit.
   function automatic logic [RW-1:0] raw_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic m);
      if (m) return {1'b0, a} - {1'b0, b};
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Final correction: s - q when s >= q for add; d + q when d < 0 for subtract.
   function automatic logic [DW-1:0] fix_f(input logic [RW-1:0] r, input logic [DW-1:0] q,
                                           input logic m);
      if (m) return r[RW-1] ? (r[DW-1:0] + q) : r[DW-1:0];
      return (r < {1'b0, q}) ? r[DW-1:0] : (r[DW-1:0] - q);
   endfunction

   logic [RBW-1:0] raw_c;

   always_comb begin
      raw_c = '0;
      for (int unsigned k = 0; k < LANES; k++)
         raw_c[k*RW +: RW] = raw_f(op0_i[k*DW +: DW], op1_i[k*DW +: DW], mode_i);
   end

   if (STAGES == 1) begin : g_one
      logic          v_q, v_d;
      logic [BW-1:0] res_q, res_d;

      assign ready_o = !v_q || ready_i;

      always_comb begin
         v_d   = v_q;
         res_d = res_q;
         if (ready_o) v_d = valid_i;
         if (ready_o && valid_i) begin
            for (int unsigned k = 0; k < LANES; k++)
               res_d[k*DW +: DW] = fix_f(raw_c[k*RW +: RW], q_i, mode_i);
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            v_q   <= 1'b0;
            res_q <= '0;
         end else begin
            v_q   <= v_d;
            res_q <= res_d;
         end
      end

      assign valid_o = v_q;
      assign res_o   = res_q;
      assign busy_o  = v_q;
   end else if (STAGES == 2) begin : g_two
      logic           v1_q, v1_d, m1_q, m1_d, v2_q, v2_d;
      logic [RBW-1:0] raw1_q, raw1_d;
      logic [DW-1:0]  q1_q, q1_d;
      logic [BW-1:0]  res2_q, res2_d;
      logic           adv2_c;

      assign adv2_c  = !v2_q || ready_i;
      assign ready_o = !v1_q || adv2_c;

      // Stage 1 captures raw s/d with its own q and mode; stage 2 applies the correction.
      always_comb begin
         v1_d   = v1_q;
         raw1_d = raw1_q;
         q1_d   = q1_q;
         m1_d   = m1_q;
         v2_d   = v2_q;
         res2_d = res2_q;
         if (ready_o) begin
            v1_d = valid_i;
            if (valid_i) begin
               raw1_d = raw_c;
               q1_d   = q_i;
               m1_d   = mode_i;
            end
         end
         if (adv2_c) begin
            v2_d = v1_q;
            if (v1_q) begin
               for (int unsigned k = 0; k < LANES; k++)
                  res2_d[k*DW +: DW] = fix_f(raw1_q[k*RW +: RW], q1_q, m1_q);
            end
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            v1_q   <= 1'b0;
            raw1_q <= '0;
            q1_q   <= '0;
            m1_q   <= 1'b0;
            v2_q   <= 1'b0;
            res2_q <= '0;
         end else begin
            v1_q   <= v1_d;
            raw1_q <= raw1_d;
            q1_q   <= q1_d;
            m1_q   <= m1_d;
            v2_q   <= v2_d;
            res2_q <= res2_d;
         end
      end

      assign valid_o = v2_q;
      assign res_o   = res2_q;
      assign busy_o  = v1_q || v2_q;
   end else begin : g_bad
      $error("mod_addsub_pipe: STAGES must be 1 or 2");
      assign ready_o = 1'b0;
      assign valid_o = 1'b0;
      assign res_o   = '0;
      assign busy_o  = 1'b0;
   end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Bench for mod_addsub_pipe: one STAGES=1 and one STAGES=2 instance, each tracked by a
// queue-based reference model, plus directed literal cases.
`timescale 1ns/1ps
module tb_mod_addsub_pipe;

   typedef struct {
      logic [255:0] res;
      longint       edge_n;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_i [2];
   logic         ready_o [2];
   logic         mode_i  [2];
   logic [31:0]  q_i     [2];
   logic [255:0] op0_i   [2];
   logic [255:0] op1_i   [2];
   logic         valid_o [2];
   logic         ready_i [2];
   logic [255:0] res_o   [2];
   logic         busy_o  [2];
   int           pending [2];
   longint       cyc = 0;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   // Reference: plain wide-integer modular arithmetic per lane.
   function automatic logic [255:0] model(input logic m, input logic [31:0] q,
                                          input logic [255:0] a, input logic [255:0] b);
      logic [255:0] r;
      longint x, y, z;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         x = longint'(a[k*32 +: 32]);
         y = longint'(b[k*32 +: 32]);
         if (!m) begin
            z = x + y;
            if (z >= longint'(q)) z = z - longint'(q);
         end else begin
            z = x - y;
            if (z < 0) z = z + longint'(q);
         end
         r[k*32 +: 32] = z[31:0];
      end
      return r;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int ST = g + 1;
      exp_t sb[$];
      logic exp_v;

      mod_addsub_pipe #(.DATA_WIDTH(32), .LANES(8), .STAGES(ST)) u_dut (
         .clk_i  (clk),
         .rst_i  (rst),
         .valid_i(valid_i[g]),
         .ready_o(ready_o[g]),
         .mode_i (mode_i[g]),
         .q_i    (q_i[g]),
         .op0_i  (op0_i[g]),
         .op1_i  (op1_i[g]),
         .valid_o(valid_o[g]),
         .ready_i(ready_i[g]),
         .res_o  (res_o[g]),
         .busy_o (busy_o[g])
      );

      // Head beat must be on the output once it has spent STAGES-1 edges in the pipe.
      always @(negedge clk) begin
         if (rst) begin
            sb.delete();
            chk($sformatf("rst_valid_o[%0d]", g), 256'(valid_o[g]), 256'(0));
            chk($sformatf("rst_busy_o[%0d]", g), 256'(busy_o[g]), 256'(0));
            chk($sformatf("rst_res_o[%0d]", g), res_o[g], 256'(0));
         end else begin
            exp_v = (sb.size() > 0) && (cyc - sb[0].edge_n >= longint'(ST - 1));
            chk($sformatf("valid_o[%0d]@%0d", g, cyc), 256'(valid_o[g]), 256'(exp_v));
            if (exp_v) chk($sformatf("res_o[%0d]@%0d", g, cyc), res_o[g], sb[0].res);
            chk($sformatf("ready_o[%0d]@%0d", g, cyc), 256'(ready_o[g]),
                256'((sb.size() < ST) || ready_i[g]));
            chk($sformatf("busy_o[%0d]@%0d", g, cyc), 256'(busy_o[g]), 256'(sb.size() > 0));
            if (valid_o[g] && ready_i[g] && sb.size() > 0) void'(sb.pop_front());
            if (valid_i[g] && ready_o[g])
               sb.push_back('{res: model(mode_i[g], q_i[g], op0_i[g], op1_i[g]), edge_n: cyc + 1});
         end
         pending[g] = sb.size();
      end
   end

   task automatic present(input int g, input logic m, input logic [31:0] q,
                          input logic [31:0] a, input logic [31:0] b);
      valid_i[g] = 1'b1;
      mode_i[g]  = m;
      q_i[g]     = q;
      op0_i[g]   = {8{a}};
      op1_i[g]   = {8{b}};
   endtask

   task automatic wait_accept(input int g);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready_o[g] && n < 100);
      chk($sformatf("accept_wait[%0d]", g), 256'(ready_o[g]), 256'(1));
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(input int g, input string name);
      int n = 0;
      while (pending[g] != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk(name, 256'(pending[g]), 256'(0));
   endtask

   // Present one beat to both instances; STAGES=1 shows it one edge, STAGES=2 two edges later.
   task automatic one_shot(input string name, input logic m, input logic [31:0] q,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
      for (int g = 0; g < 2; g++) begin
         present(g, m, q, a, b);
         ready_i[g] = 1'b1;
      end
      @(posedge clk); #1;
      valid_i[0] = 1'b0;
      valid_i[1] = 1'b0;
      chk({name, "_s1_valid"}, 256'(valid_o[0]), 256'(1));
      chk({name, "_s1_res"}, res_o[0], {8{e}});
      chk({name, "_s2_early"}, 256'(valid_o[1]), 256'(0));
      @(posedge clk); #1;
      chk({name, "_s2_valid"}, 256'(valid_o[1]), 256'(1));
      chk({name, "_s2_res"}, res_o[1], {8{e}});
      chk({name, "_s1_gone"}, 256'(valid_o[0]), 256'(0));
   endtask

   task automatic random_run(input int g);
      int          sent = 0;
      int          guard = 0;
      logic        acc;
      logic [31:0] q;
      valid_i[g] = 1'b0;
      while (sent < 1000 && guard < 20000) begin
         @(negedge clk);
         acc = valid_i[g] && ready_o[g];
         @(posedge clk); #1;
         guard++;
         if (acc) begin
            sent++;
            valid_i[g] = 1'b0;
         end
         ready_i[g] = ((sent / 100) % 3 == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
         if (!valid_i[g] && sent < 1000 && $urandom_range(7, 0) != 0) begin
            q = ($urandom_range(1, 0) != 0) ? $urandom_range(32'hFFFF_FFFF, 32'hFFFF_0000)
                                            : $urandom_range(4096, 2);
            valid_i[g] = 1'b1;
            mode_i[g]  = ($urandom_range(1, 0) != 0);
            q_i[g]     = q;
            for (int k = 0; k < 8; k++) begin
               op0_i[g][k*32 +: 32] = $urandom % q;
               op1_i[g][k*32 +: 32] = $urandom % q;
            end
         end
      end
      chk($sformatf("rand_sent[%0d]", g), 256'(sent), 256'(1000));
      valid_i[g] = 1'b0;
      ready_i[g] = 1'b1;
      wait_drain(g, $sformatf("rand_drain[%0d]", g));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         valid_i[g] = 1'b0;
         ready_i[g] = 1'b1;
         mode_i[g]  = 1'b0;
         q_i[g]     = 32'd3329;
         op0_i[g]   = '0;
         op1_i[g]   = '0;
         pending[g] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("ready_after_rst0", 256'(ready_o[0]), 256'(1));
      chk("ready_after_rst1", 256'(ready_o[1]), 256'(1));
      @(posedge clk); #1;

      // Pin the model itself against hand-computed values.
      chk("model_add", model(1'b0, 32'd3329, {8{32'd3000}}, {8{32'd1000}}), {8{32'd671}});
      chk("model_sub", model(1'b1, 32'd3329, {8{32'd5}}, {8{32'd10}}), {8{32'd3324}});
      chk("model_carry", model(1'b0, 32'hFFFF_FFFB, {8{32'hFFFF_FFFA}}, {8{32'hFFFF_FFFA}}),
          {8{32'hFFFF_FFF9}});

      one_shot("add_671", 1'b0, 32'd3329, 32'd3000, 32'd1000, 32'd671);
      one_shot("sub_wrap", 1'b1, 32'd3329, 32'd5, 32'd10, 32'd3324);
      one_shot("sub_zero", 1'b1, 32'd3329, 32'd7, 32'd7, 32'd0);
      one_shot("sub_max", 1'b1, 32'd3329, 32'd3328, 32'd0, 32'd3328);
      one_shot("add_carry", 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFF9);
      @(posedge clk); #1;

      // Backpressure on the two-stage instance: two beats fill it, beat 0 holds on the output.
      ready_i[1] = 1'b0;
      present(1, 1'b0, 32'd3329, 32'd1, 32'd3000);
      wait_accept(1);
      present(1, 1'b0, 32'd3329, 32'd101, 32'd3000);
      wait_accept(1);
      present(1, 1'b0, 32'd3329, 32'd201, 32'd3000);
      chk("bp_ready_low", 256'(ready_o[1]), 256'(0));
      chk("bp_valid", 256'(valid_o[1]), 256'(1));
      chk("bp_res_beat0", res_o[1], {8{32'd3001}});
      repeat (3) @(posedge clk);
      #1;
      chk("bp_hold_ready", 256'(ready_o[1]), 256'(0));
      chk("bp_hold_res", res_o[1], {8{32'd3001}});
      ready_i[1] = 1'b1;
      wait_accept(1);
      present(1, 1'b0, 32'd3329, 32'd301, 32'd3000);
      wait_accept(1);
      valid_i[1] = 1'b0;
      wait_drain(1, "bp_drain");
      @(posedge clk); #1;

      // Reset with beats in flight: outputs clear at once and nothing stale follows.
      for (int g = 0; g < 2; g++) begin
         ready_i[g] = 1'b0;
         present(g, 1'b1, 32'd97, 32'd3, 32'd50);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("mid_busy_before", 256'(busy_o[1]), 256'(1));
      valid_i[0] = 1'b0;
      valid_i[1] = 1'b0;
      rst = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("mid_rst_valid[%0d]", g), 256'(valid_o[g]), 256'(0));
         chk($sformatf("mid_rst_busy[%0d]", g), 256'(busy_o[g]), 256'(0));
         chk($sformatf("mid_rst_res[%0d]", g), res_o[g], 256'(0));
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ready_i[0] = 1'b1;
      ready_i[1] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++)
         chk($sformatf("post_rst_busy[%0d]", g), 256'(busy_o[g]), 256'(0));

      fork
         random_run(0);
         random_run(1);
      join

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
